// File: rtl/w_grf_if.sv
// W-stage / GRF bundle: W pipeline-register values in, D-stage read ports out,
// plus the committed-write view exported to the forwarding network.
interface w_grf_if;
    logic [31:0] instr;
    logic [31:0] PC;
    logic [31:0] ALU;
    logic [31:0] DM;
    logic [31:0] MDU;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;

    // Pipeline side: drives the W-stage payload and read addresses.
    modport master (
        output instr, PC, ALU, DM, MDU, rs_addr, rt_addr,
        input  rd1, rd2, wb_we, wb_addr, wb_data
    );

    // GRF side.
    modport slave (
        input  instr, PC, ALU, DM, MDU, rs_addr, rt_addr,
        output rd1, rd2, wb_we, wb_addr, wb_data
    );
endinterface

// File: rtl/w_grf.sv
// Write-back stage and 32x32 general register file for the 5-stage MIPS pipeline.
// Optional feature: define GRF_BYPASS_EN to let a read see the same-cycle W write.
module w_grf #(
    parameter int NREG   = 32,
    parameter int DW     = 32,
    parameter int RA_IDX = 31
) (
    input  logic     clk,
    input  logic     reset,
    w_grf_if.slave   bus
);

    typedef enum logic [1:0] {
        DST_NONE,
        DST_RD,
        DST_RT,
        DST_RA
    } dst_e;

    typedef enum logic [2:0] {
        SRC_NONE,
        SRC_ALU,
        SRC_DM,
        SRC_MDU,
        SRC_LINK
    } src_e;

    logic [5:0]    op;
    logic [5:0]    funct;
    dst_e          dst_sel;
    src_e          src_sel;
    logic [4:0]    dest_idx;
    logic [DW-1:0] src_data;
    logic [DW-1:0] link_addr;
    logic          we;
    logic [4:0]    wb_addr_q;
    logic [DW-1:0] wb_data_q;
    logic [DW-1:0] regs [NREG];
    logic          unused_instr_bits;

    assign op        = bus.instr[31:26];
    assign funct     = bus.instr[5:0];
    assign link_addr = bus.PC + 32'd8;

    assign unused_instr_bits = ^{bus.instr[25:21], bus.instr[10:6]};

    // Classify the instruction into a destination field and a result source.
    always_comb begin
        dst_sel = DST_NONE;
        src_sel = SRC_NONE;
        case (op)
            6'h00: begin
                case (funct)
                    6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h2B: begin
                        dst_sel = DST_RD;
                        src_sel = SRC_ALU;
                    end
                    6'h10, 6'h12: begin
                        dst_sel = DST_RD;
                        src_sel = SRC_MDU;
                    end
                    6'h09: begin
                        dst_sel = DST_RD;
                        src_sel = SRC_LINK;
                    end
                    default: begin
                        dst_sel = DST_NONE;
                        src_sel = SRC_NONE;
                    end
                endcase
            end
            6'h08, 6'h0C, 6'h0D, 6'h0F: begin
                dst_sel = DST_RT;
                src_sel = SRC_ALU;
            end
            6'h23, 6'h21, 6'h20: begin
                dst_sel = DST_RT;
                src_sel = SRC_DM;
            end
            6'h03: begin
                dst_sel = DST_RA;
                src_sel = SRC_LINK;
            end
            default: begin
                dst_sel = DST_NONE;
                src_sel = SRC_NONE;
            end
        endcase
    end

    always_comb begin
        dest_idx = 5'd0;
        case (dst_sel)
            DST_RD:  dest_idx = bus.instr[15:11];
            DST_RT:  dest_idx = bus.instr[20:16];
            DST_RA:  dest_idx = 5'(RA_IDX);
            default: dest_idx = 5'd0;
        endcase
    end

    always_comb begin
        src_data = '0;
        case (src_sel)
            SRC_ALU:  src_data = bus.ALU;
            SRC_DM:   src_data = bus.DM;
            SRC_MDU:  src_data = bus.MDU;
            SRC_LINK: src_data = link_addr;
            default:  src_data = '0;
        endcase
    end

    // A write aimed at $0 is squashed here so downstream never sees it as live.
    assign we        = (dst_sel != DST_NONE) && (dest_idx != 5'd0);
    assign wb_addr_q = we ? dest_idx : 5'd0;
    assign wb_data_q = we ? src_data : '0;

    assign bus.wb_we   = we;
    assign bus.wb_addr = wb_addr_q;
    assign bus.wb_data = wb_data_q;

    // Reset takes priority over the write pending in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[wb_addr_q] <= wb_data_q;
        end
    end

    always_comb begin
        bus.rd1 = '0;
        if (bus.rs_addr != 5'd0) begin
`ifdef GRF_BYPASS_EN
            if (we && (wb_addr_q == bus.rs_addr)) begin
                bus.rd1 = wb_data_q;
            end else begin
                bus.rd1 = regs[bus.rs_addr];
            end
`else
            bus.rd1 = regs[bus.rs_addr];
`endif
        end
    end

    always_comb begin
        bus.rd2 = '0;
        if (bus.rt_addr != 5'd0) begin
`ifdef GRF_BYPASS_EN
            if (we && (wb_addr_q == bus.rt_addr)) begin
                bus.rd2 = wb_data_q;
            end else begin
                bus.rd2 = regs[bus.rt_addr];
            end
`else
            bus.rd2 = regs[bus.rt_addr];
`endif
        end
    end

endmodule

// File: tb/tb_w_grf.sv
// Directed bench for w_grf: vector table for decode/commit plus hand-written
// sequences for reset sweep, same-cycle read-after-write and reset-vs-write.
module tb_w_grf;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    w_grf_if bus ();

    w_grf dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] alu;
        logic [31:0] dm;
        logic [31:0] mdu;
        logic        exp_we;
        logic [4:0]  exp_addr;
        logic [31:0] exp_data;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] model_regs [32];

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] pc,
                                 input logic [31:0] alu, input logic [31:0] dm,
                                 input logic [31:0] mdu, input logic [4:0] rs,
                                 input logic [4:0] rt);
        bus.instr   = instr;
        bus.PC      = pc;
        bus.ALU     = alu;
        bus.DM      = dm;
        bus.MDU     = mdu;
        bus.rs_addr = rs;
        bus.rt_addr = rt;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic addVec(input string name, input logic [31:0] instr,
                          input logic [31:0] pc, input logic [31:0] alu,
                          input logic [31:0] dm, input logic [31:0] mdu,
                          input logic we, input logic [4:0] addr,
                          input logic [31:0] data);
        vec_t v;
        v.name = name; v.instr = instr; v.pc = pc; v.alu = alu; v.dm = dm;
        v.mdu = mdu; v.exp_we = we; v.exp_addr = addr; v.exp_data = data;
        vecs.push_back(v);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 32; i++) model_regs[i] = 32'h0;

        addVec("ori5",     32'h34051234, 32'h0,        32'h00001234, 32'h0,        32'h0,        1'b1, 5'd5,  32'h00001234);
        addVec("jal",      32'h0C000C00, 32'h00003000, 32'h0,        32'h0,        32'h0,        1'b1, 5'd31, 32'h00003008);
        addVec("jalwrap",  32'h0C000C00, 32'hFFFFFFFC, 32'h0,        32'h0,        32'h0,        1'b1, 5'd31, 32'h00000004);
        addVec("add0",     32'h00430020, 32'h0,        32'hDEADBEEF, 32'h0,        32'h0,        1'b0, 5'd0,  32'h0);
        addVec("mfhi7",    32'h00003810, 32'h0,        32'h0,        32'h0,        32'h00000055, 1'b1, 5'd7,  32'h00000055);
        addVec("sw",       32'hAC080000, 32'h0,        32'h11111111, 32'h22222222, 32'h0,        1'b0, 5'd0,  32'h0);
        addVec("beq",      32'h10430004, 32'h0,        32'h33333333, 32'h0,        32'h0,        1'b0, 5'd0,  32'h0);
        addVec("mult",     32'h00430018, 32'h0,        32'h44444444, 32'h0,        32'h55555555, 1'b0, 5'd0,  32'h0);
        addVec("sub10",    32'h00435022, 32'h0,        32'h12345678, 32'h0,        32'h0,        1'b1, 5'd10, 32'h12345678);
        addVec("lui12",    32'h3C0CABCD, 32'h0,        32'hABCD0000, 32'h0,        32'h0,        1'b1, 5'd12, 32'hABCD0000);
        addVec("lb13",     32'h800D0004, 32'h0,        32'h00000004, 32'hFFFFFF80, 32'h0,        1'b1, 5'd13, 32'hFFFFFF80);
        addVec("jalr14",   32'h00407009, 32'h00000100, 32'h0,        32'h0,        32'h0,        1'b1, 5'd14, 32'h00000108);
        addVec("mflo15",   32'h00007812, 32'h0,        32'h0,        32'h0,        32'hCAFEF00D, 1'b1, 5'd15, 32'hCAFEF00D);
        addVec("sltu16",   32'h0043802B, 32'h0,        32'h00000001, 32'h0,        32'h0,        1'b1, 5'd16, 32'h00000001);
        addVec("ori0",     32'h34001234, 32'h0,        32'h00001234, 32'h0,        32'h0,        1'b0, 5'd0,  32'h0);
        addVec("jalr0",    32'h00400009, 32'h00000200, 32'h0,        32'h0,        32'h0,        1'b0, 5'd0,  32'h0);
        addVec("addu",     32'h00432021, 32'h0,        32'h66666666, 32'h0,        32'h0,        1'b0, 5'd0,  32'h0);
        addVec("nop",      32'h00000000, 32'h0,        32'h77777777, 32'h0,        32'h0,        1'b0, 5'd0,  32'h0);
        addVec("lh17",     32'h84110002, 32'h0,        32'h00000002, 32'h00007FFF, 32'h0,        1'b1, 5'd17, 32'h00007FFF);
        addVec("addi18",   32'h20120005, 32'h0,        32'h00000005, 32'h0,        32'h0,        1'b1, 5'd18, 32'h00000005);
        addVec("andi19",   32'h30130F0F, 32'h0,        32'h00000F0F, 32'h0,        32'h0,        1'b1, 5'd19, 32'h00000F0F);
        addVec("and20",    32'h0043A024, 32'h0,        32'h000000F0, 32'h0,        32'h0,        1'b1, 5'd20, 32'h000000F0);
        addVec("or21",     32'h0043A825, 32'h0,        32'hFF00FF00, 32'h0,        32'h0,        1'b1, 5'd21, 32'hFF00FF00);
        addVec("slt22",    32'h0043B02A, 32'h0,        32'h00000001, 32'h0,        32'h0,        1'b1, 5'd22, 32'h00000001);

        // Reset, then sweep every index on both ports.
        reset = 1'b1;
        applyStimulus(32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0);
        nextCycle();
        reset = 1'b0;
        for (int i = 0; i < 32; i++) begin
            bus.rs_addr = 5'(i);
            bus.rt_addr = 5'(31 - i);
            #1;
            checkOutput($sformatf("reset_rd1[%0d]", i), bus.rd1, 32'h0);
            checkOutput($sformatf("reset_rd2[%0d]", 31 - i), bus.rd2, 32'h0);
        end
        checkOutput("reset_wb_we", {31'h0, bus.wb_we}, 32'h0);

        // Table: check W-stage outputs, commit, then read back next cycle.
        for (int k = 0; k < vecs.size(); k++) begin
            applyStimulus(vecs[k].instr, vecs[k].pc, vecs[k].alu, vecs[k].dm,
                          vecs[k].mdu, 5'd0, 5'd0);
            #1;
            checkOutput({vecs[k].name, "_we"},   {31'h0, bus.wb_we},  {31'h0, vecs[k].exp_we});
            checkOutput({vecs[k].name, "_addr"}, {27'h0, bus.wb_addr}, {27'h0, vecs[k].exp_addr});
            checkOutput({vecs[k].name, "_data"}, bus.wb_data,          vecs[k].exp_data);
            checkOutput({vecs[k].name, "_rd1_r0"}, bus.rd1, 32'h0);
            if (vecs[k].exp_we) model_regs[vecs[k].exp_addr] = vecs[k].exp_data;
            nextCycle();
            applyStimulus(32'h0, 32'h0, 32'h0, 32'h0, 32'h0, vecs[k].exp_addr, 5'd5);
            #1;
            checkOutput({vecs[k].name, "_rd1_after"}, bus.rd1, model_regs[vecs[k].exp_addr]);
            checkOutput({vecs[k].name, "_rd2_r5"},    bus.rd2, model_regs[5]);
        end

        // Store $8=0x11, then lw $8 with both ports reading $8 in the write cycle.
        applyStimulus(32'h34080011, 32'h0, 32'h00000011, 32'h0, 32'h0, 5'd0, 5'd0);
        nextCycle();
        applyStimulus(32'h8C080000, 32'h0, 32'h0, 32'h00000022, 32'h0, 5'd8, 5'd8);
        #1;
`ifdef GRF_BYPASS_EN
        checkOutput("raw_same_rd1", bus.rd1, 32'h00000022);
        checkOutput("raw_same_rd2", bus.rd2, 32'h00000022);
`else
        checkOutput("raw_same_rd1", bus.rd1, 32'h00000011);
        checkOutput("raw_same_rd2", bus.rd2, 32'h00000011);
`endif
        nextCycle();
        applyStimulus(32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd8, 5'd8);
        #1;
        checkOutput("raw_next_rd1", bus.rd1, 32'h00000022);
        checkOutput("raw_next_rd2", bus.rd2, 32'h00000022);

        // Reset asserted alongside lw $9: the write must be dropped, all regs cleared.
        applyStimulus(32'h8C090000, 32'h0, 32'h0, 32'h00000099, 32'h0, 5'd9, 5'd5);
        reset = 1'b1;
        #1;
        checkOutput("rst_lw_we",   {31'h0, bus.wb_we},  32'h1);
        checkOutput("rst_lw_addr", {27'h0, bus.wb_addr}, 32'h9);
        nextCycle();
        reset = 1'b0;
        applyStimulus(32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd9, 5'd5);
        #1;
        checkOutput("rst_r9", bus.rd1, 32'h0);
        checkOutput("rst_r5", bus.rd2, 32'h0);
        bus.rs_addr = 5'd31;
        bus.rt_addr = 5'd8;
        #1;
        checkOutput("rst_r31", bus.rd1, 32'h0);
        checkOutput("rst_r8",  bus.rd2, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
